// File: rtl/vjtag_cmd_sequencer.sv
// rtl/vjtag_cmd_sequencer.sv - virtual-JTAG byte command sequencer driving a req/ack register bus
module vjtag_cmd_sequencer #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          aclr,
  input  logic [DW-1:0] jtag_wr_data,
  input  logic          jtag_wr_toggle,
  output logic          bus_req,
  output logic          bus_we,
  output logic [DW-2:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata,
  output logic [DW-1:0] rd_data,
  output logic [DW-1:0] status
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO        = CW'(TIMEOUT);
  localparam logic [DW-1:0] CMD_RESYNC = {DW{1'b1}};
  localparam logic [DW-1:0] CMD_CLR    = {{(DW-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, WDATA, BUS} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            tog_s1;
  logic            tog_s2;
  logic            tog_s3;
  logic            strobe;
  logic            is_resync;
  logic            is_clr;
  logic            cmd_we;
  logic            tmo_hit;
  logic            bus_entry;
  logic            busy;
  logic            pend_we;
  logic [DW-2:0]   pend_addr;
  logic [CW-1:0]   cnt;
  logic            rd_valid;
  logic            err_timeout;
  logic            err_overrun;

  // Two-flop synchronizer for the TCK-domain toggle, third flop for edge detection
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      tog_s1 <= 1'b0;
      tog_s2 <= 1'b0;
      tog_s3 <= 1'b0;
    end else begin
      tog_s1 <= jtag_wr_toggle;
      tog_s2 <= tog_s1;
      tog_s3 <= tog_s2;
    end
  end

  assign strobe    = tog_s2 ^ tog_s3;
  assign is_resync = (jtag_wr_data == CMD_RESYNC);
  assign is_clr    = (jtag_wr_data == CMD_CLR);
  assign cmd_we    = jtag_wr_data[DW-1];
  assign tmo_hit   = (cnt == TMO);
  assign bus_entry = (state != BUS) && (state_nxt == BUS);

  // State register
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: command parse, write-data capture, bus completion or timeout
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (strobe && !is_resync && !is_clr) state_nxt = cmd_we ? WDATA : BUS;
      WDATA:   if (strobe) state_nxt = is_resync ? IDLE : BUS;
      BUS:     if (bus_ack || tmo_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state and status flops only; nothing passes straight from inputs
  always_comb begin
    bus_req = (state == BUS);
    busy    = (state != IDLE);
    status  = {err_timeout, err_overrun, busy, rd_valid, {(DW-4){1'b0}}};
  end

  // Cycle counter for the current bus transaction; zero whenever not in BUS
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr)              cnt <= '0;
    else if (state != BUS)  cnt <= '0;
    else if (!tmo_hit)      cnt <= cnt + CW'(1);
  end

  // Bus address/direction/data are loaded only on BUS entry so they move together with req
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      pend_we   <= 1'b0;
      pend_addr <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      if (state == IDLE && strobe && !is_resync && !is_clr) begin
        pend_we   <= cmd_we;
        pend_addr <= jtag_wr_data[DW-2:0];
      end
      if (bus_entry) begin
        if (state == IDLE) begin
          bus_we   <= cmd_we;
          bus_addr <= jtag_wr_data[DW-2:0];
        end else begin
          bus_we    <= pend_we;
          bus_addr  <= pend_addr;
          bus_wdata <= jtag_wr_data;
        end
      end
    end
  end

  // Read result and sticky status flags
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (strobe && is_clr) begin
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
          end else if (strobe && !is_resync && !cmd_we) begin
            rd_valid <= 1'b0;
          end
        end
        WDATA: begin
          if (strobe && !is_resync) rd_valid <= 1'b0;
        end
        BUS: begin
          if (strobe) err_overrun <= 1'b1;
          if (bus_ack) begin
            if (!bus_we) begin
              rd_data  <= bus_rdata;
              rd_valid <= 1'b1;
            end
          end else if (tmo_hit) begin
            err_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vjtag_cmd_sequencer.sv
// tb/tb_vjtag_cmd_sequencer.sv - directed bench for vjtag_cmd_sequencer
module tb_vjtag_cmd_sequencer;

  logic       clk;
  logic       aclr;
  logic [7:0] jtag_wr_data;
  logic       jtag_wr_toggle;
  logic       bus_ack;
  logic [7:0] bus_rdata;

  logic       req_l, we_l, req_s, we_s;
  logic [6:0] addr_l, addr_s;
  logic [7:0] wdata_l, rd_l, st_l, wdata_s, rd_s, st_s;

  int n_cmp;
  int n_err;
  int req_cycles;
  logic req_seen;

  vjtag_cmd_sequencer #(.DW(8), .TIMEOUT(255)) u_dut_long (
    .clk(clk), .aclr(aclr), .jtag_wr_data(jtag_wr_data), .jtag_wr_toggle(jtag_wr_toggle),
    .bus_req(req_l), .bus_we(we_l), .bus_addr(addr_l), .bus_wdata(wdata_l),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .rd_data(rd_l), .status(st_l)
  );

  vjtag_cmd_sequencer #(.DW(8), .TIMEOUT(4)) u_dut_short (
    .clk(clk), .aclr(aclr), .jtag_wr_data(jtag_wr_data), .jtag_wr_toggle(jtag_wr_toggle),
    .bus_req(req_s), .bus_we(we_s), .bus_addr(addr_s), .bus_wdata(wdata_s),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .rd_data(rd_s), .status(st_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns #1 after the edge on which the byte is consumed
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    jtag_wr_data   = b;
    jtag_wr_toggle = ~jtag_wr_toggle;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // One-cycle ack; returns #1 after the edge that samples it
  task automatic ack_once(input logic [7:0] d);
    @(negedge clk);
    bus_ack   = 1'b1;
    bus_rdata = d;
    @(posedge clk);
    #1;
    @(negedge clk);
    bus_ack = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    aclr           = 1'b0;
    jtag_wr_toggle = 1'b0;
    bus_ack        = 1'b0;
    @(negedge clk);
    aclr = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    aclr = 1'b0;
    jtag_wr_data = 8'h00;
    jtag_wr_toggle = 1'b0;
    bus_ack = 1'b0;
    bus_rdata = 8'h00;

    // Reset values: activity on inputs while held in reset
    req_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 1 || i == 4) jtag_wr_toggle = ~jtag_wr_toggle;
      jtag_wr_data = 8'h85;
      bus_ack = (i == 2 || i == 5);
      bus_rdata = 8'hEE;
      @(posedge clk);
      #1;
      req_seen = req_seen | req_l | req_s;
    end
    chk("rst_req_never", req_seen, 0);
    chk("rst_we", we_l, 0);
    chk("rst_addr", addr_l, 0);
    chk("rst_wdata", wdata_l, 0);
    chk("rst_rd_data", rd_l, 0);
    chk("rst_status", st_l, 0);
    @(negedge clk);
    bus_ack = 1'b0;
    aclr = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_idle", st_l, 8'h00);

    // Write 0x85, 0x3C
    send_byte(8'h85);
    chk("wr_wdata_busy", st_l, 8'h20);
    chk("wr_no_req_yet", req_l, 0);
    send_byte(8'h3C);
    chk("wr_req", req_l, 1);
    chk("wr_we", we_l, 1);
    chk("wr_addr", addr_l, 7'h05);
    chk("wr_wdata", wdata_l, 8'h3C);
    @(posedge clk); #1;
    chk("wr_req_hold1", req_l, 1);
    @(posedge clk); #1;
    chk("wr_req_hold2", req_l, 1);
    ack_once(8'h00);
    chk("wr_req_drop", req_l, 0);
    chk("wr_status", st_l, 8'h00);

    // Read 0x12 acked on first req cycle
    send_byte(8'h12);
    chk("rd_req", req_l, 1);
    chk("rd_we", we_l, 0);
    chk("rd_addr", addr_l, 7'h12);
    @(negedge clk);
    bus_ack = 1'b1;
    bus_rdata = 8'hA7;
    @(posedge clk); #1;
    chk("rd_req_drop", req_l, 0);
    chk("rd_data", rd_l, 8'hA7);
    chk("rd_status", st_l, 8'h10);
    @(negedge clk);
    bus_ack = 1'b0;
    // Stray ack while idle must be ignored
    ack_once(8'hFF);
    chk("idle_ack_rd", rd_l, 8'hA7);
    chk("idle_ack_st", st_l, 8'h10);
    // Second read clears rd_valid while busy
    send_byte(8'h13);
    chk("rd2_status", st_l, 8'h20);
    chk("rd2_keep_data", rd_l, 8'hA7);
    ack_once(8'h5A);
    chk("rd2_data", rd_l, 8'h5A);
    chk("rd2_status_done", st_l, 8'h10);

    // Timeout on the TIMEOUT=4 instance
    send_byte(8'h01);
    req_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (req_s) req_cycles++;
      @(posedge clk); #1;
    end
    chk("tmo_req_cycles", req_cycles, 5);
    chk("tmo_status", st_s, 8'h80);
    chk("tmo_rd_data", rd_s, 8'h5A);
    send_byte(8'hFE);
    chk("clr_err_status", st_s, 8'h00);

    pulse_reset();
    @(posedge clk); #1;
    chk("rst2_status", st_l, 8'h00);

    // Overrun: byte during BUS dropped, ack late
    send_byte(8'h02);
    chk("ovr_req", req_l, 1);
    send_byte(8'h55);
    chk("ovr_status_busy", st_l, 8'h60);
    chk("ovr_req_hold", req_l, 1);
    chk("ovr_addr_kept", addr_l, 7'h02);
    repeat (14) @(posedge clk);
    ack_once(8'hC4);
    chk("ovr_req_drop", req_l, 0);
    chk("ovr_rd_data", rd_l, 8'hC4);
    chk("ovr_status", st_l, 8'h50);
    // Resync aborts a pending write
    send_byte(8'h90);
    chk("rsy_wdata_busy", st_l, 8'h70);
    send_byte(8'hFF);
    chk("rsy_idle", st_l, 8'h50);
    req_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      req_seen = req_seen | req_l;
    end
    chk("rsy_no_req", req_seen, 0);

    // 0x7F as read command reads normally
    send_byte(8'h7F);
    chk("r7f_req", req_l, 1);
    chk("r7f_addr", addr_l, 7'h7F);
    ack_once(8'h66);
    chk("r7f_data", rd_l, 8'h66);

    // Reset in the middle of a transaction
    send_byte(8'h84);
    send_byte(8'h11);
    chk("mid_req", req_l, 1);
    @(negedge clk);
    aclr = 1'b0;
    jtag_wr_toggle = 1'b0;
    #1;
    chk("mid_req_async", req_l, 0);
    chk("mid_status", st_l, 8'h00);
    chk("mid_rd_data", rd_l, 8'h00);
    chk("mid_addr", addr_l, 7'h00);
    @(negedge clk);
    aclr = 1'b1;
    send_byte(8'h81);
    send_byte(8'h01);
    chk("post_req", req_l, 1);
    chk("post_we", we_l, 1);
    chk("post_addr", addr_l, 7'h01);
    chk("post_wdata", wdata_l, 8'h01);
    ack_once(8'h00);
    chk("post_req_drop", req_l, 0);
    chk("post_status", st_l, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vjtag_cmd_sequencer.md
# vjtag_cmd_sequencer

Command sequencer between the virtual-JTAG byte interface and the FPGA-side register bus. Runs in the system clock domain: synchronizes byte-update events from the TCK domain, parses 1- or 2-byte command packets, performs a single read or write on a req/ack register bus with timeout, and exposes read data plus a status byte for the JTAG READ path.

## Interface
Parameters:
- DW, 8: JTAG byte width; address width is DW-1.
- TIMEOUT, 255: max clk cycles req may stay high without ack; must be ≥1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- aclr  in  1  reset aclr, asynchronous, active-low.
- jtag_wr_data  in  DW  byte last updated by JTAG WRITE (TCK domain, quasi-static).
- jtag_wr_toggle  in  1  toggles in TCK domain once per completed JTAG WRITE update.
- bus_req  out  1  bus transaction request.
- bus_we  out  1  1 = write, 0 = read; valid while bus_req.
- bus_addr  out  DW-1  register address; valid while bus_req.
- bus_wdata  out  DW  write data; valid while bus_req && bus_we.
- bus_ack  in  1  single-cycle completion from bus slave.
- bus_rdata  in  DW  read data, valid when bus_ack && !bus_we.
- rd_data  out  DW  last successful read result (to JTAG data_in).
- status  out  DW  {err_timeout, err_overrun, busy, rd_valid, zeros}; MSB first.

## Operation
- Reset (aclr low, any time, including mid-transaction): state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, rd_data=0, status=0, sync flops=0, timeout counter=0. First toggle edge after release counts as one byte only if toggle level differs from the synchronized value.
- Byte strobe: jtag_wr_toggle through 2-flop synchronizer, third flop for edge detect; strobe = sync2 ^ sync3 (one clk pulse). jtag_wr_data sampled on strobe cycle.
- Command byte: bit DW-1 = we, bits DW-2:0 = address. Reserved: all-ones (DW-1 ones after we=1), i.e. 0xFF = RESYNC, and 0xFE = CLEAR_ERR (clears err_timeout, err_overrun). Addresses 0x7E/0x7F with we=1 are therefore not writable; with we=0 they read normally.
- FSM states: IDLE, WDATA, BUS.
  - IDLE + strobe: 0xFF → stay IDLE; 0xFE → clear errors, stay IDLE; we=1 → latch addr, go WDATA; we=0 → latch addr, clear rd_valid, go BUS (read).
  - WDATA + strobe: byte 0xFF → IDLE (abort, no bus cycle); any other byte → bus_wdata, clear rd_valid, go BUS (write). A data byte of 0xFF cannot be written; this is accepted.
  - BUS: bus_req=1. On bus_ack: read → rd_data=bus_rdata, rd_valid=1; go IDLE. If counter reaches TIMEOUT without ack: set err_timeout, rd_data unchanged, rd_valid stays 0, go IDLE. Strobe in BUS: byte dropped, err_overrun set (sticky).
- busy = (state != IDLE).
- bus_ack while bus_req=0 is ignored.

## Timing
- Strobe asserts on the 3rd clk edge after jtag_wr_toggle changes (2 sync + 1 edge). Sender must keep jtag_wr_data stable ≥4 clk after toggle; guaranteed when clk ≥ TCK since next update needs ≥DW TCK.
- bus_req rises on clk edge after the strobe of the final packet byte (registered); bus_addr/bus_we/bus_wdata change on same edge and remain stable while bus_req=1.
- bus_ack sampled on any edge with bus_req=1 (including the first); bus_req falls on that same edge's next state, i.e. low the cycle after ack is seen. rd_data/rd_valid update on that edge.
- Timeout counter clears on BUS entry, increments each cycle in BUS; cycle with count == TIMEOUT and no ack drops req (req high exactly TIMEOUT+1 cycles max). Ack on the TIMEOUT cycle wins; no error.
- Strobe and ack in same cycle in BUS: ack completes, byte dropped, err_overrun set.
- status and rd_data registered; no combinational path from inputs to outputs.

## Test plan
- Reset values: hold aclr low, toggle jtag_wr_toggle, pulse bus_ack -> all outputs 0, bus_req never rises.
- Write: bytes 0x85, 0x3C -> one bus_req cycle with we=1, addr=0x05, wdata=0x3C; ack after 2 cycles -> req low next cycle, status=0x00.
- Read: byte 0x12, slave acks with rdata=0xA7 on first req cycle -> rd_data=0xA7, status=0x10; second read 0x13 clears rd_valid while busy (status=0x20).
- Timeout: TIMEOUT=4, byte 0x01, no ack -> req high 5 cycles, status=0x80, rd_data unchanged; then byte 0xFE -> status=0x00.
- Overrun and resync: byte 0x02 with ack delayed 20 cycles, extra byte 0x55 during BUS -> dropped, status bit6 set; bytes 0x90, 0xFF -> no bus cycle, IDLE.
- Reset mid-transaction: aclr low while bus_req=1 -> bus_req low asynchronously, FSM IDLE; next packet 0x81, 0x01 writes normally.
